uart_word_loader: RTL and testbench

- Controller that sequences the byte-level UART receiver (serial_receive) and turns its byte stream into 32-bit little-endian words for the core's program/data loader.
- Detects the start-bit edge on the raw RX line and arms the receiver with a one-cycle Ready pulse.
- Collects four received bytes into one word and buffers completed words in a small FIFO drained by a valid/ack consumer.
- Sits between the RX pin, serial_receive and the boot-load / MMIO logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/word_fifo.sv | 62 ++++++
 rtl/uart_word_loader.sv | 161 ++++++++++++++++
 tb/tb_uart_word_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word loader and its serial_receive hookup.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2
  } loader_state_t;

  localparam int unsigned UART_WAIT_DIV  = 434;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_fifo.sv
// Circular word FIFO. A push while full succeeds only when a pop frees a slot in the same cycle.
module word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_word_loader.sv
// Sequences serial_receive and packs its bytes into little-endian 32-bit words buffered in a FIFO.
// Define RX_TIMEOUT_EN to discard a partial word after TIMEOUT_CYC idle cycles (adds rx_timeout).
module uart_word_loader
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 43400
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          rx_in,
  output logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [31:0]                   word_out,
  output logic                          word_valid,
  input  logic                          word_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
`ifdef RX_TIMEOUT_EN
  output logic                          rx_timeout,
`endif
  output loader_state_t                 dbg_state,
  output logic [BYTE_CNT_W-1:0]         dbg_byte_cnt
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1))
  begin : g_bad_param
    $error("uart_word_loader: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYC >= 1");
  end

  // Handshakes: rx_ready is a one-cycle arm pulse; rx_valid qualifies rx_data in its own
  // cycle and is honoured only in S_WAIT; word_valid/word_ack pop the head on the clock
  // edge where both are high, and word_ack with word_valid low does nothing.

  loader_state_t            state_q, state_d;
  logic [BYTE_CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]              word_q, word_d;
  logic                     rx_meta_q, rx_sync_q, rx_prev_q;
  logic                     start_edge;
  logic                     push, pop, fifo_full, fifo_empty, drop;
  logic [31:0]              push_word;
  logic                     overflow_q, overflow_d;
  logic                     timeout_hit;

  assign start_edge = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            rx_timeout_q;

  // Counts only while a partial word sits idle; any start edge restarts the wait.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if ((state_q == S_IDLE) && (byte_cnt_q != '0) && !start_edge) begin
      if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
      else                                       idle_cnt_d  = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_cnt_q   <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      rx_timeout_q <= timeout_hit;
    end
  end

  assign rx_timeout = rx_timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    push       = 1'b0;
    rx_ready   = 1'b0;
    case (state_q)
      S_IDLE: if (start_edge) state_d = S_ARM;
      S_ARM: begin
        rx_ready = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (rx_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = S_IDLE;
          if (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1)) push = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) byte_cnt_d = '0;
    // The completing byte is not yet in word_q, so push the merged value.
    push_word = word_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop  = word_ack & ~fifo_empty;
  assign drop = push & fifo_full & ~pop;

  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (word_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign word_valid   = ~fifo_empty;
  assign overflow     = overflow_q;
  assign dbg_state    = state_q;
  assign dbg_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed + randomized bench for uart_word_loader; a queue model of bytes/words is the reference.
`timescale 1ns/1ps
module tb_uart_word_loader;
  import uart_pkg::*;

  localparam int DEPTH  = 4;
  localparam int TO_CYC = 1000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  rx_in = 1'b1;
  logic                  rx_ready;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic [31:0]           word_out;
  logic                  word_valid;
  logic                  word_ack = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  overflow;
  logic                  ovf_clr = 1'b0;
  loader_state_t         dbg_state;
  logic [BYTE_CNT_W-1:0] dbg_byte_cnt;
`ifdef RX_TIMEOUT_EN
  logic                  rx_timeout;
  int                    to_cnt = 0;
`endif

  uart_word_loader #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .rx_in        (rx_in),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ack     (word_ack),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
`ifdef RX_TIMEOUT_EN
    .rx_timeout   (rx_timeout),
`endif
    .dbg_state    (dbg_state),
    .dbg_byte_cnt (dbg_byte_cnt)
  );

  // Clock and pulse monitors
  always #5 clk = ~clk;

  int ready_cnt = 0;
  always @(posedge clk) if (rx_ready) ready_cnt++;
`ifdef RX_TIMEOUT_EN
  always @(posedge clk) if (rx_timeout) to_cnt++;
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: completed words awaiting drain, bytes of the word in progress, sticky flag
  logic [31:0] exp_q[$];
  logic [7:0]  part_q[$];
  logic        exp_ovf = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(exp_q.size() != 0));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(exp_q.size()));
    chk({tag, ".overflow"},   32'(overflow),   32'(exp_ovf));
    chk({tag, ".byte_cnt"},   32'(dbg_byte_cnt), 32'(part_q.size()));
    if (exp_q.size() != 0) chk({tag, ".word_out"}, word_out, exp_q[0]);
  endtask

  // Driver: one byte through the arm/receive handshake, receiver emulated behaviourally
  task automatic send_byte(input logic [7:0] b, input bit ack, input bit glitch);
    int  lat;
    int  r0;
    bit  seen;
    logic [31:0] w;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    r0   = ready_cnt;
    rx_in = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (rx_ready) seen = 1'b1;
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("ready_latency_le3", 32'(lat <= 3), 32'd1);
    @(negedge clk);
    chk("state_wait", 32'(dbg_state), 32'(S_WAIT));
    if (glitch) begin
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      rx_in = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    word_ack = ack;
    if (ack && exp_q.size() != 0) chk("ack_head", word_out, exp_q[0]);
    @(negedge clk);
    rx_valid = 1'b0;
    word_ack = 1'b0;
    if (ack && exp_q.size() != 0) void'(exp_q.pop_front());
    part_q.push_back(b);
    if (part_q.size() == 4) begin
      w = {part_q[3], part_q[2], part_q[1], part_q[0]};
      part_q.delete();
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else                      exp_ovf = 1'b1;
    end
    chk("ready_pulses_per_byte", 32'(ready_cnt - r0), 32'd1);
    check_all("byte");
  endtask

  task automatic send_word(input logic [31:0] w, input bit ack_last);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], ack_last && (i == 3), 1'b0);
  endtask

  task automatic pop_word();
    word_ack = 1'b1;
    if (exp_q.size() != 0) chk("pop_head", word_out, exp_q[0]);
    @(negedge clk);
    word_ack = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_all("pop");
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_in    = 1'b1;
    rx_valid = 1'b0;
    word_ack = 1'b0;
    ovf_clr  = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    part_q.delete();
    exp_ovf = 1'b0;
    chk("rst.rx_ready",   32'(rx_ready),     32'd0);
    chk("rst.word_valid", 32'(word_valid),   32'd0);
    chk("rst.fifo_count", 32'(fifo_count),   32'd0);
    chk("rst.overflow",   32'(overflow),     32'd0);
    chk("rst.word_out",   word_out,          32'd0);
    chk("rst.state",      32'(dbg_state),    32'(S_IDLE));
    chk("rst.byte_cnt",   32'(dbg_byte_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int r0;
    logic [31:0] w;

    // Reset state
    do_reset();

    // Basic word assembly, little-endian
    r0 = ready_cnt;
    send_byte(8'h78, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    chk("basic.ready_pulses", 32'(ready_cnt - r0), 32'd4);
    chk("basic.word_out",     word_out,             32'h1234_5678);
    chk("basic.fifo_count",   32'(fifo_count),      32'd1);
    pop_word();
    pop_word();

    // Overflow: five words, no draining
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
    chk("ovf.fifo_count", 32'(fifo_count), 32'd4);
    chk("ovf.overflow",   32'(overflow),   32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf.cleared", 32'(overflow), 32'd0);

    // Full FIFO, completing byte coincides with a pop
    send_word(32'hCAFE_F00D, 1'b1);
    chk("fullack.fifo_count", 32'(fifo_count), 32'd4);
    chk("fullack.overflow",   32'(overflow),   32'd0);
    for (int i = 0; i < 3; i++) pop_word();
    chk("fullack.last_word", word_out, 32'hCAFE_F00D);
    pop_word();
    chk("fullack.empty", 32'(word_valid), 32'd0);

    // Line glitch while waiting, then stray rx_valid while idle
    r0 = ready_cnt;
    send_byte(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch.ready_pulses", 32'(ready_cnt - r0), 32'd1);
    chk("glitch.byte_cnt",     32'(dbg_byte_cnt),   32'd1);
    chk("glitch.state_idle",   32'(dbg_state),      32'(S_IDLE));
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    chk("glitch.word", word_out, 32'hC33C_5AA5);
    pop_word();

    // Reset mid-word discards partial bytes; in-flight rx_valid afterwards is ignored
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    do_reset();
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rst_mid.byte_cnt", 32'(dbg_byte_cnt), 32'd0);
    send_word(32'hDDCC_BBAA, 1'b0);
    chk("rst_mid.word", word_out, 32'hDDCC_BBAA);
    pop_word();

    // Randomized traffic against the queue model
    for (int i = 0; i < 12; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], ($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 2) == 0) pop_word();
      if (exp_ovf && $urandom_range(0, 1) == 1) begin
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check_all("rand_clr");
      end
    end
    while (exp_q.size() != 0) pop_word();
    check_all("rand_drained");

`ifdef RX_TIMEOUT_EN
    // Partial word abandoned after the idle timeout
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    send_byte(8'h77, 1'b0, 1'b0);
    repeat (TO_CYC - 20) @(negedge clk);
    chk("timeout.not_early", 32'(to_cnt), 32'd0);
    r0 = 0;
    while (to_cnt == 0 && r0 < 100) begin
      @(negedge clk);
      r0++;
    end
    chk("timeout.pulsed", 32'(to_cnt), 32'd1);
    @(negedge clk);
    chk("timeout.one_cycle", 32'(rx_timeout), 32'd0);
    part_q.delete();
    chk("timeout.byte_cnt", 32'(dbg_byte_cnt), 32'd0);
    send_word(32'h0403_0201, 1'b0);
    chk("timeout.word", word_out, 32'h0403_0201);
    pop_word();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
